// File: rtl/event_ctrl.sv
// -----------------------------------------------------------------------------
// event_ctrl
//
// Event controller for a time-multiplexed neuron array. It accepts external
// AER events over a 4-phase handshake and pushes them into the scheduler FIFO
// as virtual events. When the FIFO holds events, it pops one at a time:
//  - a virtual event (non-zero weight) updates one neuron with that weight,
//  - a spike event (zero weight) sweeps all N neurons through the synapse
//    array, stalling while the FIFO is full so no output spike is lost.
//
// Ports
//   clk, rst_n            : clock (rising edge) and async active-low reset
//   aer_req / aer_ack     : external AER 4-phase handshake (req is async)
//   aer_addr              : {virts, neuron addr} of the external event
//   sched_empty/full      : scheduler FIFO status
//   sched_data_out        : FIFO head, first-word fall-through
//   ctrl_sched_pop_n      : active-low FIFO pop
//   ctrl_sched_event_in   : push code (7'b0000010 = virtual push)
//   ctrl_sched_virts/addr : virtual event pushed from AER
//   ctrl_neurmem_addr/en  : neuron memory address and update strobe
//   ctrl_syn_addr         : synapse address {source, neuron}
//   ctrl_virt_w           : weight for the current update (0 = use synapse)
//   ctrl_busy             : controller is not idle
// -----------------------------------------------------------------------------
module event_ctrl #(
  parameter int N         = 256,
  parameter int M         = 8,
  parameter int VIRT_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 aer_req,
  input  logic [VIRT_BITS+M-1:0] aer_addr,
  output logic                 aer_ack,
  input  logic                 sched_empty,
  input  logic                 sched_full,
  input  logic [VIRT_BITS+M-1:0] sched_data_out,
  output logic                 ctrl_sched_pop_n,
  output logic [6:0]           ctrl_sched_event_in,
  output logic [VIRT_BITS-1:0] ctrl_sched_virts,
  output logic [M-1:0]         ctrl_sched_addr,
  output logic [M-1:0]         ctrl_neurmem_addr,
  output logic                 ctrl_neurmem_en,
  output logic [2*M-1:0]       ctrl_syn_addr,
  output logic [VIRT_BITS-1:0] ctrl_virt_w,
  output logic                 ctrl_busy
);

  localparam int W = VIRT_BITS + M;
  localparam logic [6:0]   EV_VIRT_PUSH = 7'b0000010;
  localparam logic [M-1:0] CNT_LAST     = M'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AER_PUSH,
    S_AER_ACK,
    S_POP,
    S_SWEEP,
    S_VIRT,
    S_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [M-1:0]         cnt_q, cnt_d;
  logic [M-1:0]         src_q, src_d;
  logic [VIRT_BITS-1:0] virts_q, virts_d;
  logic                 req_meta_q, req_sync_q;

  // NOTE: aer_req is asynchronous to clk; two flops bound metastability and
  // only req_sync_q may feed any decision logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta_q <= 1'b0;
      req_sync_q <= 1'b0;
    end else begin
      req_meta_q <= aer_req;
      req_sync_q <= req_meta_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      virts_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      virts_q <= virts_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    src_d               = src_q;
    virts_d             = virts_q;
    aer_ack             = 1'b0;
    ctrl_sched_pop_n    = 1'b1;
    ctrl_sched_event_in = '0;
    ctrl_sched_virts    = '0;
    ctrl_sched_addr     = '0;
    ctrl_neurmem_addr   = cnt_q;
    ctrl_neurmem_en     = 1'b0;
    ctrl_virt_w         = '0;

    unique case (state_q)
      S_IDLE: begin
        // External events take priority over draining the FIFO.
        if (req_sync_q)        state_d = S_AER_PUSH;
        else if (!sched_empty) state_d = S_POP;
      end

      S_AER_PUSH: begin
        ctrl_sched_virts = aer_addr[W-1:M];
        ctrl_sched_addr  = aer_addr[M-1:0];
        if (!sched_full) begin
          ctrl_sched_event_in = EV_VIRT_PUSH;
          state_d             = S_AER_ACK;
        end
      end

      S_AER_ACK: begin
        aer_ack = 1'b1;
        if (!req_sync_q) state_d = S_IDLE;
      end

      S_POP: begin
        // Gating on sched_empty guarantees no pop of an empty FIFO.
        if (!sched_empty) begin
          ctrl_sched_pop_n = 1'b0;
          src_d            = sched_data_out[M-1:0];
          virts_d          = sched_data_out[W-1:M];
          if (sched_data_out[W-1:M] != '0) begin
            state_d = S_VIRT;
          end else begin
            cnt_d   = '0;
            state_d = S_SWEEP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SWEEP: begin
        // A full FIFO cannot accept the spike this update might produce,
        // so the update is held rather than dropped.
        if (!sched_full) begin
          ctrl_neurmem_en = 1'b1;
          cnt_d           = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end

      S_VIRT: begin
        ctrl_neurmem_en   = 1'b1;
        ctrl_neurmem_addr = src_q;
        ctrl_virt_w       = virts_q;
        state_d           = S_IDLE;
      end

      S_WAIT: begin
        // Lets the spike from the last sweep update reach the FIFO.
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign ctrl_syn_addr = {src_q, ctrl_neurmem_addr};
  assign ctrl_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_event_ctrl
//
// Directed bench for event_ctrl. The scheduler FIFO is driven by hand: the
// bench presents a head word, waits for the pop, then marks the FIFO empty.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_event_ctrl;

  localparam int N = 256;
  localparam int M = 8;
  localparam int VB = 4;

  logic            clk;
  logic            rst_n;
  logic            aer_req;
  logic [VB+M-1:0] aer_addr;
  logic            aer_ack;
  logic            sched_empty;
  logic            sched_full;
  logic [VB+M-1:0] sched_data_out;
  logic            ctrl_sched_pop_n;
  logic [6:0]      ctrl_sched_event_in;
  logic [VB-1:0]   ctrl_sched_virts;
  logic [M-1:0]    ctrl_sched_addr;
  logic [M-1:0]    ctrl_neurmem_addr;
  logic            ctrl_neurmem_en;
  logic [2*M-1:0]  ctrl_syn_addr;
  logic [VB-1:0]   ctrl_virt_w;
  logic            ctrl_busy;

  int checks = 0;
  int errors = 0;

  event_ctrl #(.N(N), .M(M), .VIRT_BITS(VB)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .aer_req             (aer_req),
    .aer_addr            (aer_addr),
    .aer_ack             (aer_ack),
    .sched_empty         (sched_empty),
    .sched_full          (sched_full),
    .sched_data_out      (sched_data_out),
    .ctrl_sched_pop_n    (ctrl_sched_pop_n),
    .ctrl_sched_event_in (ctrl_sched_event_in),
    .ctrl_sched_virts    (ctrl_sched_virts),
    .ctrl_sched_addr     (ctrl_sched_addr),
    .ctrl_neurmem_addr   (ctrl_neurmem_addr),
    .ctrl_neurmem_en     (ctrl_neurmem_en),
    .ctrl_syn_addr       (ctrl_syn_addr),
    .ctrl_virt_w         (ctrl_virt_w),
    .ctrl_busy           (ctrl_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", ctrl_busy); end
    checks++; if (ctrl_sched_pop_n !== 1'b1) begin errors++; $display("FAIL rst_pop_n got=%b exp=1", ctrl_sched_pop_n); end
    checks++; if (ctrl_sched_event_in !== 7'd0) begin errors++; $display("FAIL rst_event_in got=%h exp=0", ctrl_sched_event_in); end
    checks++; if (aer_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", aer_ack); end
    checks++; if (ctrl_neurmem_en !== 1'b0) begin errors++; $display("FAIL rst_en got=%b exp=0", ctrl_neurmem_en); end
    checks++; if (ctrl_syn_addr !== 16'h0) begin errors++; $display("FAIL rst_syn_addr got=%h exp=0", ctrl_syn_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();
    checks++; if (ctrl_busy !== 1'b0 || ctrl_sched_pop_n !== 1'b1) begin
      errors++; $display("FAIL rst_release_idle busy=%b pop_n=%b exp busy=0 pop_n=1", ctrl_busy, ctrl_sched_pop_n);
    end
  endtask

  // Basic AER push and full handshake.
  task automatic test_aer();
    bit found = 1'b0;
    aer_addr = {4'h3, 8'h25};
    aer_req  = 1'b1;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (ctrl_sched_event_in == 7'd2) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL aer_push_seen got=0 exp=1"); end
    checks++; if (ctrl_sched_virts !== 4'h3 || ctrl_sched_addr !== 8'h25) begin
      errors++; $display("FAIL aer_push_fields got=%h/%h exp=3/25", ctrl_sched_virts, ctrl_sched_addr);
    end
    checks++; if (ctrl_busy !== 1'b1 || aer_ack !== 1'b0) begin
      errors++; $display("FAIL aer_push_state busy=%b ack=%b exp busy=1 ack=0", ctrl_busy, aer_ack);
    end
    step();
    checks++; if (ctrl_sched_event_in !== 7'd0) begin errors++; $display("FAIL aer_push_one_cycle got=%h exp=0", ctrl_sched_event_in); end
    checks++; if (aer_ack !== 1'b1) begin errors++; $display("FAIL aer_ack_rise got=%b exp=1", aer_ack); end
    repeat (3) step();
    checks++; if (aer_ack !== 1'b1) begin errors++; $display("FAIL aer_ack_hold got=%b exp=1", aer_ack); end
    aer_req = 1'b0;
    step();
    step();
    checks++; if (aer_ack !== 1'b1) begin errors++; $display("FAIL aer_ack_sync_delay got=%b exp=1", aer_ack); end
    step();
    checks++; if (aer_ack !== 1'b0 || ctrl_busy !== 1'b0) begin
      errors++; $display("FAIL aer_ack_fall ack=%b busy=%b exp ack=0 busy=0", aer_ack, ctrl_busy);
    end
  endtask

  // AER push held off by a full FIFO.
  task automatic test_aer_full();
    bit found = 1'b0;
    bit bad   = 1'b0;
    aer_addr   = {4'hA, 8'hC3};
    sched_full = 1'b1;
    aer_req    = 1'b1;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (ctrl_busy) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL aer_full_start got=0 exp=1"); end
    for (int i = 0; i < 3; i++) begin
      if (ctrl_sched_event_in !== 7'd0 || aer_ack !== 1'b0 || ctrl_busy !== 1'b1) bad = 1'b1;
      step();
    end
    checks++; if (bad) begin errors++; $display("FAIL aer_full_hold got=push_or_ack exp=no_push"); end
    sched_full = 1'b0;
    #1;
    checks++; if (ctrl_sched_event_in !== 7'd2 || ctrl_sched_virts !== 4'hA || ctrl_sched_addr !== 8'hC3) begin
      errors++; $display("FAIL aer_full_resume got=%h/%h/%h exp=02/a/c3", ctrl_sched_event_in, ctrl_sched_virts, ctrl_sched_addr);
    end
    step();
    checks++; if (aer_ack !== 1'b1) begin errors++; $display("FAIL aer_full_ack got=%b exp=1", aer_ack); end
    aer_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      if (!aer_ack && !ctrl_busy) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL aer_full_done got=busy exp=idle"); end
  endtask

  // Presents a head word and waits for the pop; reports whether it happened.
  task automatic start_pop(input logic [VB+M-1:0] head, output bit popped);
    popped         = 1'b0;
    sched_data_out = head;
    sched_empty    = 1'b0;
    for (int i = 0; i < 8 && !popped; i++) begin
      step();
      if (ctrl_sched_pop_n == 1'b0) popped = 1'b1;
    end
    step();
    sched_empty = 1'b1;
    #1;
  endtask

  task automatic test_sweep();
    bit popped;
    start_pop({4'h0, 8'h10}, popped);
    checks++; if (!popped) begin errors++; $display("FAIL sweep_pop got=0 exp=1"); end
    checks++; if (ctrl_sched_pop_n !== 1'b1) begin errors++; $display("FAIL sweep_single_pop got=%b exp=1", ctrl_sched_pop_n); end
    for (int i = 0; i < N; i++) begin
      checks++; if (ctrl_neurmem_en !== 1'b1) begin errors++; $display("FAIL sweep_en[%0d] got=%b exp=1", i, ctrl_neurmem_en); end
      checks++; if (ctrl_neurmem_addr !== 8'(i)) begin errors++; $display("FAIL sweep_addr[%0d] got=%h exp=%h", i, ctrl_neurmem_addr, 8'(i)); end
      checks++; if (ctrl_syn_addr !== {8'h10, 8'(i)} || ctrl_virt_w !== 4'h0) begin
        errors++; $display("FAIL sweep_syn[%0d] got=%h/%h exp=%h/0", i, ctrl_syn_addr, ctrl_virt_w, {8'h10, 8'(i)});
      end
      step();
    end
    checks++; if (ctrl_neurmem_en !== 1'b0 || ctrl_busy !== 1'b1) begin
      errors++; $display("FAIL sweep_wait en=%b busy=%b exp en=0 busy=1", ctrl_neurmem_en, ctrl_busy);
    end
    step();
    checks++; if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL sweep_idle got=%b exp=0", ctrl_busy); end
  endtask

  task automatic test_virt();
    bit popped;
    start_pop({4'h5, 8'h7A}, popped);
    checks++; if (!popped) begin errors++; $display("FAIL virt_pop got=0 exp=1"); end
    checks++; if (ctrl_neurmem_en !== 1'b1 || ctrl_neurmem_addr !== 8'h7A || ctrl_virt_w !== 4'h5) begin
      errors++; $display("FAIL virt_update got=%b/%h/%h exp=1/7a/5", ctrl_neurmem_en, ctrl_neurmem_addr, ctrl_virt_w);
    end
    step();
    checks++; if (ctrl_neurmem_en !== 1'b0 || ctrl_busy !== 1'b0) begin
      errors++; $display("FAIL virt_single en=%b busy=%b exp en=0 busy=0", ctrl_neurmem_en, ctrl_busy);
    end
  endtask

  // Back-pressure from a full FIFO at counter 40 for three cycles.
  task automatic test_full_stall();
    bit popped;
    int exp_cnt = 0;
    start_pop({4'h0, 8'h5C}, popped);
    checks++; if (!popped) begin errors++; $display("FAIL stall_pop got=0 exp=1"); end
    for (int cyc = 0; cyc < 300 && exp_cnt < N; cyc++) begin
      sched_full = (cyc >= 40 && cyc < 43);
      #1;
      if (sched_full) begin
        checks++; if (ctrl_neurmem_en !== 1'b0 || ctrl_neurmem_addr !== 8'd40) begin
          errors++; $display("FAIL stall_hold[%0d] got=%b/%h exp=0/28", cyc, ctrl_neurmem_en, ctrl_neurmem_addr);
        end
      end else begin
        checks++; if (ctrl_neurmem_en !== 1'b1 || ctrl_neurmem_addr !== 8'(exp_cnt)) begin
          errors++; $display("FAIL stall_update[%0d] got=%b/%h exp=1/%h", cyc, ctrl_neurmem_en, ctrl_neurmem_addr, 8'(exp_cnt));
        end
        exp_cnt++;
      end
      step();
    end
    sched_full = 1'b0;
    #1;
    checks++; if (ctrl_neurmem_en !== 1'b0 || ctrl_busy !== 1'b1) begin
      errors++; $display("FAIL stall_wait en=%b busy=%b exp en=0 busy=1", ctrl_neurmem_en, ctrl_busy);
    end
    step();
    checks++; if (ctrl_busy !== 1'b0) begin errors++; $display("FAIL stall_idle got=%b exp=0", ctrl_busy); end
  endtask

  // AER and a non-empty FIFO seen in the same IDLE cycle: AER wins.
  task automatic test_priority();
    bit found  = 1'b0;
    bit popped = 1'b0;
    bit bad    = 1'b0;
    aer_addr = {4'h1, 8'h99};
    aer_req  = 1'b1;
    step();
    step();
    sched_data_out = {4'h2, 8'h33};
    sched_empty    = 1'b0;
    step();
    checks++; if (ctrl_sched_event_in !== 7'd2 || ctrl_sched_pop_n !== 1'b1) begin
      errors++; $display("FAIL prio_aer_first got=%h/%b exp=02/1", ctrl_sched_event_in, ctrl_sched_pop_n);
    end
    step();
    step();
    aer_req = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (ctrl_sched_pop_n !== 1'b1) bad = 1'b1;
      step();
      if (!aer_ack) found = 1'b1;
    end
    checks++; if (!found || bad) begin
      errors++; $display("FAIL prio_handshake done=%b early_pop=%b exp done=1 early_pop=0", found, bad);
    end
    for (int i = 0; i < 4 && !popped; i++) begin
      step();
      if (ctrl_sched_pop_n == 1'b0) popped = 1'b1;
    end
    checks++; if (!popped) begin errors++; $display("FAIL prio_pop_after got=0 exp=1"); end
    step();
    sched_empty = 1'b1;
    #1;
    checks++; if (ctrl_neurmem_en !== 1'b1 || ctrl_neurmem_addr !== 8'h33 || ctrl_virt_w !== 4'h2) begin
      errors++; $display("FAIL prio_virt got=%b/%h/%h exp=1/33/2", ctrl_neurmem_en, ctrl_neurmem_addr, ctrl_virt_w);
    end
    step();
  endtask

  task automatic test_reset_mid_sweep();
    bit popped;
    bit bad = 1'b0;
    start_pop({4'h0, 8'h44}, popped);
    checks++; if (!popped) begin errors++; $display("FAIL rmid_pop got=0 exp=1"); end
    repeat (100) step();
    checks++; if (ctrl_neurmem_addr !== 8'd100 || ctrl_neurmem_en !== 1'b1) begin
      errors++; $display("FAIL rmid_reach100 got=%h/%b exp=64/1", ctrl_neurmem_addr, ctrl_neurmem_en);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (ctrl_busy !== 1'b0 || ctrl_neurmem_en !== 1'b0 || ctrl_neurmem_addr !== 8'h0) begin
      errors++; $display("FAIL rmid_state got=%b/%b/%h exp=0/0/00", ctrl_busy, ctrl_neurmem_en, ctrl_neurmem_addr);
    end
    checks++; if (ctrl_syn_addr !== 16'h0 || ctrl_virt_w !== 4'h0 || ctrl_sched_pop_n !== 1'b1) begin
      errors++; $display("FAIL rmid_outputs got=%h/%h/%b exp=0000/0/1", ctrl_syn_addr, ctrl_virt_w, ctrl_sched_pop_n);
    end
    checks++; if (ctrl_sched_event_in !== 7'd0 || aer_ack !== 1'b0 || ctrl_sched_virts !== 4'h0 || ctrl_sched_addr !== 8'h0) begin
      errors++; $display("FAIL rmid_push got=%h/%b/%h/%h exp=00/0/0/00", ctrl_sched_event_in, aer_ack, ctrl_sched_virts, ctrl_sched_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ctrl_sched_pop_n !== 1'b1 || ctrl_busy !== 1'b0 || ctrl_neurmem_en !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL rmid_quiet got=activity exp=idle"); end
  endtask

  initial begin
    rst_n          = 1'b0;
    aer_req        = 1'b0;
    aer_addr       = '0;
    sched_empty    = 1'b1;
    sched_full     = 1'b0;
    sched_data_out = '0;
    test_reset();
    test_aer();
    test_aer_full();
    test_sweep();
    test_virt();
    test_full_stall();
    test_priority();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
